ram_loader: RTL and testbench

- Writer side of the 256×32 table RAM: turns a serial byte stream into RAM writes and reference-register updates.
- Sits between the byte receiver (UART RX) and the RAM write port (Address_w, W, W_ref, Data_I).
- Parses framed commands and packs bytes little-endian into 32-bit words.
- Guards against truncated frames with an inter-byte timeout.

---
 rtl/ram_loader_pkg.sv | 23 ++
 rtl/ram_loader_byte_packer.sv | 61 ++++++
 rtl/ram_loader.sv | 213 +++++++++++++++++++++
 tb/tb_ram_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// ----------------------------------------------------------------------------
// ram_loader_pkg
// Shared definitions for the table-RAM writer: FSM state encoding, default
// command bytes and the RAM geometry (256 words x 32 bits).
// ----------------------------------------------------------------------------
package ram_loader_pkg;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 32;

    localparam logic [7:0] CMD_LOAD_DEF = 8'hA5;
    localparam logic [7:0] CMD_REF_DEF  = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_COUNT,
        ST_DATA,
        ST_REF_LO,
        ST_REF_HI
    } state_t;

endpackage

// File: rtl/ram_loader_byte_packer.sv
// ----------------------------------------------------------------------------
// ram_loader_byte_packer
// Assembles four consecutive bytes little-endian into one 32-bit word.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   clear     in   return the byte index to 0 (held while not in a data phase)
//   byte_vld  in   byte_in is a payload byte this cycle
//   byte_in   in   payload byte
//   word_o    out  assembled word; valid only while word_rdy is high
//   word_rdy  out  the current byte completes a word (combinational)
// ----------------------------------------------------------------------------
module ram_loader_byte_packer
    import ram_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  byte_vld,
    input  logic [7:0]            byte_in,
    output logic [RAM_DATA_W-1:0] word_o,
    output logic                  word_rdy
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] low_q, low_d;

    always_comb begin
        idx_d = idx_q;
        low_d = low_q;
        if (clear) begin
            idx_d = 2'd0;
        end else if (byte_vld) begin
            // 2-bit index wraps 3 -> 0 on its own after the word completes
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    low_d[7:0]   = byte_in;
                2'd1:    low_d[15:8]  = byte_in;
                2'd2:    low_d[23:16] = byte_in;
                default: low_d        = low_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            low_q <= 24'd0;
        end else begin
            idx_q <= idx_d;
            low_q <= low_d;
        end
    end

    // The top byte is taken straight from the input so the word is complete
    // in the cycle its last byte arrives, letting W register one edge later.
    assign word_o   = {byte_in, low_q};
    assign word_rdy = byte_vld && !clear && (idx_q == 2'd3);

endmodule

// File: rtl/ram_loader.sv
// ----------------------------------------------------------------------------
// ram_loader
// Writer side of the 256x32 table RAM. Parses framed commands from a serial
// byte stream:
//   CMD_LOAD, start address, count N (0 = 256), 4*N payload bytes
//   CMD_REF,  ref low byte, ref high byte
// and turns them into registered RAM word writes / reference-register writes.
// An inter-byte timeout aborts truncated frames.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   Rx_Data    in   received byte
//   Rx_Valid   in   one-cycle strobe qualifying Rx_Data
//   Address_w  out  RAM write address (held between writes)
//   W          out  RAM word write strobe, one cycle
//   W_ref      out  reference register write strobe, one cycle
//   Data_I     out  write data (reference uses [15:0]), held between writes
//   Busy       out  a frame is in progress
//   Done       out  one-cycle pulse on frame completion
//   Err        out  one-cycle pulse on abort (timeout or bad command)
// ----------------------------------------------------------------------------
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] CMD_LOAD    = CMD_LOAD_DEF,
    parameter logic [7:0] CMD_REF     = CMD_REF_DEF
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            Rx_Data,
    input  logic                  Rx_Valid,
    output logic [RAM_ADDR_W-1:0] Address_w,
    output logic                  W,
    output logic                  W_ref,
    output logic [RAM_DATA_W-1:0] Data_I,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TMO_MAX  = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TMO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t                  state_q, state_d;
    logic [RAM_ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [RAM_ADDR_W-1:0]   addr_w_q, addr_w_d;
    logic [8:0]              cnt_q, cnt_d;
    logic [7:0]              ref_lo_q, ref_lo_d;
    logic [RAM_DATA_W-1:0]   data_q, data_d;
    logic                    w_q, w_d;
    logic                    wref_q, wref_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [TO_W-1:0]         tmo_q, tmo_d;

    logic                    pk_clear;
    logic                    pk_vld;
    logic [RAM_DATA_W-1:0]   pk_word;
    logic                    pk_rdy;
    logic                    tmo_expire;

    assign pk_clear = (state_q != ST_DATA);
    assign pk_vld   = Rx_Valid && (state_q == ST_DATA);

    ram_loader_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (pk_clear),
        .byte_vld (pk_vld),
        .byte_in  (Rx_Data),
        .word_o   (pk_word),
        .word_rdy (pk_rdy)
    );

    // Fires on the TIMEOUT_CYC-th consecutive idle cycle inside a frame.
    assign tmo_expire = (state_q != ST_IDLE) && !Rx_Valid && (tmo_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        addr_w_d   = addr_w_q;
        cnt_d      = cnt_q;
        ref_lo_d   = ref_lo_q;
        data_d     = data_q;
        w_d        = 1'b0;
        wref_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        tmo_d      = tmo_q;

        if (state_q == ST_IDLE || Rx_Valid) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TO_W'(1);
        end

        // Busy drops the cycle after Done/Err; a command byte accepted in
        // that same cycle overrides this below and keeps Busy high.
        if (done_q || err_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (Rx_Valid) begin
                    if (Rx_Data == CMD_LOAD) begin
                        state_d = ST_ADDR;
                        busy_d  = 1'b1;
                    end else if (Rx_Data == CMD_REF) begin
                        state_d = ST_REF_LO;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (Rx_Valid) begin
                    cur_addr_d = Rx_Data;
                    state_d    = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (Rx_Valid) begin
                    cnt_d   = (Rx_Data == 8'd0) ? 9'd256 : {1'b0, Rx_Data};
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (pk_rdy) begin
                    w_d        = 1'b1;
                    data_d     = pk_word;
                    addr_w_d   = cur_addr_q;
                    cur_addr_d = cur_addr_q + 8'd1;
                    cnt_d      = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REF_LO: begin
                if (Rx_Valid) begin
                    ref_lo_d = Rx_Data;
                    state_d  = ST_REF_HI;
                end
            end
            ST_REF_HI: begin
                if (Rx_Valid) begin
                    data_d  = {16'h0000, Rx_Data, ref_lo_q};
                    wref_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort only happens on a cycle without Rx_Valid, so no strobe can
        // have been requested above; the partial word is simply dropped.
        if (tmo_expire) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            addr_w_q   <= '0;
            cnt_q      <= '0;
            ref_lo_q   <= '0;
            data_q     <= '0;
            w_q        <= 1'b0;
            wref_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            addr_w_q   <= addr_w_d;
            cnt_q      <= cnt_d;
            ref_lo_q   <= ref_lo_d;
            data_q     <= data_d;
            w_q        <= w_d;
            wref_q     <= wref_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign Address_w = addr_w_q;
    assign W         = w_q;
    assign W_ref     = wref_q;
    assign Data_I    = data_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_ram_loader.sv
// ----------------------------------------------------------------------------
// tb_ram_loader
// Self-checking bench for ram_loader: a table of short frames, hand-written
// multi-cycle sequences (latency, count-zero, timeout, reset mid-frame) and a
// randomized frame stream checked against a frame-level reference model.
// ----------------------------------------------------------------------------
module tb_ram_loader;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  Rx_Data;
    logic        Rx_Valid;
    logic [7:0]  Address_w;
    logic        W;
    logic        W_ref;
    logic [31:0] Data_I;
    logic        Busy;
    logic        Done;
    logic        Err;

    ram_loader #(.TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Rx_Data   (Rx_Data),
        .Rx_Valid  (Rx_Valid),
        .Address_w (Address_w),
        .W         (W),
        .W_ref     (W_ref),
        .Data_I    (Data_I),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Event monitor: records every strobe seen on the falling edge.
    logic [7:0]  mon_addr[$];
    logic [31:0] mon_data[$];
    logic [31:0] mon_ref[$];
    int          mon_done = 0;
    int          mon_err  = 0;
    int          viol     = 0;
    bit          mon_en   = 1'b0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (W) begin
                mon_addr.push_back(Address_w);
                mon_data.push_back(Data_I);
            end
            if (W_ref) mon_ref.push_back(Data_I);
            if (Done) mon_done++;
            if (Err) mon_err++;
            if (W && W_ref) viol++;
            if (Done && Err) viol++;
            if (Done && !(W || W_ref)) viol++;
        end
    end

    typedef struct {
        int          nb;
        logic [95:0] b;
        int          nw;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [7:0]  a1;
        logic [31:0] d1;
        int          nref;
        logic [31:0] rdata;
        int          ndone;
        int          nerr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_ref.delete();
        mon_done = 0;
        mon_err  = 0;
        mon_en   = 1'b1;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_byte(input logic [7:0] b);
        Rx_Data  = b;
        Rx_Valid = 1'b1;
        @(negedge clk);
        Rx_Valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp_a[$];
        logic [31:0] exp_d[$];
        logic [31:0] exp_r[$];
        logic [31:0] cz_data[256];
        logic [31:0] word;
        logic [7:0]  addr;
        logic [7:0]  bb;
        int          exp_done;
        int          exp_err;
        int          bad;
        int          errk;
        int          n;
        int          kind;
        logic        busy_mid;

        // ---------------- reset state ----------------
        rst_n    = 1'b0;
        Rx_Data  = 8'h00;
        Rx_Valid = 1'b0;
        #12;
        check("rst_addr", 32'(Address_w), 32'h0);
        check("rst_w", 32'(W), 32'h0);
        check("rst_wref", 32'(W_ref), 32'h0);
        check("rst_data", Data_I, 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_done", 32'(Done), 32'h0);
        check("rst_err", 32'(Err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // ---------------- table-driven frames ----------------
        vecs[0] = '{11, 96'h88776655_44332211_0210A5, 2, 8'h10, 32'h44332211, 8'h11, 32'h88776655, 0, 32'h0, 1, 0};
        vecs[1] = '{11, 96'h08070605_04030201_02FFA5, 2, 8'hFF, 32'h04030201, 8'h00, 32'h08070605, 0, 32'h0, 1, 0};
        vecs[2] = '{3,  96'h12345A, 0, 8'h00, 32'h0, 8'h00, 32'h0, 1, 32'h00001234, 1, 0};
        vecs[3] = '{1,  96'h3C, 0, 8'h00, 32'h0, 8'h00, 32'h0, 0, 32'h0, 0, 1};
        vecs[4] = '{7,  96'hEFBEADDE017FA5, 1, 8'h7F, 32'hEFBEADDE, 8'h00, 32'h0, 0, 32'h0, 1, 0};

        for (int v = 0; v < 5; v++) begin
            clear_mon();
            for (int i = 0; i < vecs[v].nb; i++) begin
                bb = vecs[v].b[8*i +: 8];
                send_byte(bb);
            end
            idle(3);
            check($sformatf("vec%0d_nw", v), 32'(mon_addr.size()), 32'(vecs[v].nw));
            if (vecs[v].nw > 0 && mon_addr.size() > 0) begin
                check($sformatf("vec%0d_a0", v), 32'(mon_addr[0]), 32'(vecs[v].a0));
                check($sformatf("vec%0d_d0", v), mon_data[0], vecs[v].d0);
            end
            if (vecs[v].nw > 1 && mon_addr.size() > 1) begin
                check($sformatf("vec%0d_a1", v), 32'(mon_addr[1]), 32'(vecs[v].a1));
                check($sformatf("vec%0d_d1", v), mon_data[1], vecs[v].d1);
            end
            check($sformatf("vec%0d_nref", v), 32'(mon_ref.size()), 32'(vecs[v].nref));
            if (vecs[v].nref > 0 && mon_ref.size() > 0)
                check($sformatf("vec%0d_rdata", v), mon_ref[0], vecs[v].rdata);
            check($sformatf("vec%0d_done", v), 32'(mon_done), 32'(vecs[v].ndone));
            check($sformatf("vec%0d_err", v), 32'(mon_err), 32'(vecs[v].nerr));
            check($sformatf("vec%0d_busy_end", v), 32'(Busy), 32'h0);
        end

        // ---------------- latency / Busy / hold ----------------
        clear_mon();
        check("lat_busy_pre", 32'(Busy), 32'h0);
        send_byte(8'hA5);
        check("lat_busy_up", 32'(Busy), 32'h1);
        send_byte(8'h30);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("lat_w_pre", 32'(W), 32'h0);
        send_byte(8'h04);
        check("lat_w", 32'(W), 32'h1);
        check("lat_addr", 32'(Address_w), 32'h30);
        check("lat_data", Data_I, 32'h04030201);
        check("lat_done_with_w", 32'(Done), 32'h1);
        check("lat_busy_at_done", 32'(Busy), 32'h1);
        @(negedge clk);
        check("lat_w_one_cycle", 32'(W), 32'h0);
        check("lat_busy_fall", 32'(Busy), 32'h0);
        check("lat_addr_hold", 32'(Address_w), 32'h30);
        check("lat_data_hold", Data_I, 32'h04030201);

        // ---------------- count zero: 256 words ----------------
        idle(2);
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            cz_data[i] = $urandom;
            for (int k = 0; k < 4; k++) begin
                word = cz_data[i];
                bb = word[8*k +: 8];
                send_byte(bb);
            end
        end
        idle(3);
        check("cz_nw", 32'(mon_addr.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < 256 && i < mon_addr.size(); i++) begin
            if (mon_addr[i] !== 8'(i) || mon_data[i] !== cz_data[i]) bad++;
        end
        check("cz_words", 32'(bad), 32'h0);
        check("cz_done", 32'(mon_done), 32'h1);

        // ---------------- timeout ----------------
        idle(2);
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        errk = -1;
        busy_mid = 1'b0;
        for (int k = 1; k <= TMO + 6; k++) begin
            if (k == TMO - 1) busy_mid = Busy;
            if (Err === 1'b1 && errk < 0) errk = k;
            @(negedge clk);
        end
        check("tmo_busy_mid", 32'(busy_mid), 32'h1);
        check("tmo_err_window", 32'(errk >= TMO && errk <= TMO + 2), 32'h1);
        check("tmo_err_cnt", 32'(mon_err), 32'h1);
        check("tmo_no_w", 32'(mon_addr.size()), 32'h0);
        check("tmo_busy_fall", 32'(Busy), 32'h0);
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        idle(3);
        check("tmo_reload_nw", 32'(mon_addr.size()), 32'h1);
        if (mon_addr.size() > 0) begin
            check("tmo_reload_addr", 32'(mon_addr[0]), 32'h20);
            check("tmo_reload_data", mon_data[0], 32'h04030201);
        end
        check("tmo_reload_done", 32'(mon_done), 32'h1);

        // ---------------- reset mid-word ----------------
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h40);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        check("rmid_busy_pre", 32'(Busy), 32'h1);
        check("rmid_addr_pre", 32'(Address_w), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid_addr", 32'(Address_w), 32'h0);
        check("rmid_data", Data_I, 32'h0);
        check("rmid_busy", 32'(Busy), 32'h0);
        check("rmid_w", 32'(W), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        clear_mon();
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'hA5);
        send_byte(8'h40);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        idle(3);
        check("rmid_err", 32'(mon_err), 32'h2);
        check("rmid_nw", 32'(mon_addr.size()), 32'h1);
        if (mon_addr.size() > 0) begin
            check("rmid_new_addr", 32'(mon_addr[0]), 32'h40);
            check("rmid_new_data", mon_data[0], 32'hDDCCBBAA);
        end
        check("rmid_done", 32'(mon_done), 32'h1);

        // ---------------- randomized frame stream ----------------
        clear_mon();
        exp_done = 0;
        exp_err  = 0;
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                addr = 8'($urandom);
                if ($urandom_range(0, 3) == 0) addr = 8'hFE;
                n = $urandom_range(1, 5);
                send_byte(8'hA5);
                idle($urandom_range(0, 2));
                send_byte(addr);
                idle($urandom_range(0, 2));
                send_byte(8'(n));
                for (int i = 0; i < n; i++) begin
                    word = $urandom;
                    exp_a.push_back(addr + 8'(i));
                    exp_d.push_back(word);
                    for (int k = 0; k < 4; k++) begin
                        idle($urandom_range(0, 2));
                        bb = word[8*k +: 8];
                        send_byte(bb);
                    end
                end
                exp_done++;
            end else if (kind == 1) begin
                word = $urandom;
                send_byte(8'h5A);
                idle($urandom_range(0, 2));
                send_byte(word[7:0]);
                idle($urandom_range(0, 2));
                send_byte(word[15:8]);
                exp_r.push_back({16'h0000, word[15:0]});
                exp_done++;
            end else begin
                bb = 8'($urandom);
                while (bb == 8'hA5 || bb == 8'h5A) bb = 8'($urandom);
                send_byte(bb);
                exp_err++;
            end
            idle($urandom_range(0, 1));
        end
        idle(3);
        check("rnd_nw", 32'(mon_addr.size()), 32'(exp_a.size()));
        bad = 0;
        for (int i = 0; i < exp_a.size() && i < mon_addr.size(); i++) begin
            if (mon_addr[i] !== exp_a[i] || mon_data[i] !== exp_d[i]) bad++;
        end
        check("rnd_words", 32'(bad), 32'h0);
        check("rnd_nref", 32'(mon_ref.size()), 32'(exp_r.size()));
        bad = 0;
        for (int i = 0; i < exp_r.size() && i < mon_ref.size(); i++) begin
            if (mon_ref[i] !== exp_r[i]) bad++;
        end
        check("rnd_refs", 32'(bad), 32'h0);
        check("rnd_done", 32'(mon_done), 32'(exp_done));
        check("rnd_err", 32'(mon_err), 32'(exp_err));

        check("exclusive_strobes", 32'(viol), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
